// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: fixed-priority writeback with starvation override,
// round-robin among the other requesters, and a sequenced bulk clear of r1..r31.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_reg,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    ctrl_writeEnable,
  output logic [4:0]              ctrl_writeReg,
  output logic [31:0]             data_writeReg,
  output logic [7:0]              drop_count
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t       r_state, w_state_nxt;
  logic [2:0]   r_rr_ptr;
  logic [7:0]   r_starve_cnt;
  logic [4:0]   r_clear_cnt;
  logic [7:0]   r_drop_count;
  logic         r_we;
  logic [4:0]   r_wreg;
  logic [31:0]  r_wdata;

  logic [7:0]          w_valid_pad;
  logic                w_lp_any;
  logic [2:0]          w_idx;
  logic                w_rr_found;
  logic [2:0]          w_rr_idx;
  logic                w_gvalid;
  logic [2:0]          w_gidx;
  logic [NUM_REQ-1:0]  w_grant;
  logic [4:0]          w_sel_reg;
  logic [31:0]         w_sel_data;

  assign w_valid_pad = 8'(req_valid);
  assign w_lp_any    = |req_valid[NUM_REQ-1:1];

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_idx       = '0;
    w_rr_found  = 1'b0;
    w_rr_idx    = 3'd1;
    w_gvalid    = 1'b0;
    w_gidx      = '0;
    w_state_nxt = r_state;

    // Round-robin search starts at rr_ptr and wraps within 1..NUM_REQ-1, never touching 0.
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      w_idx = 3'(((int'(r_rr_ptr) - 1 + k) % (NUM_REQ - 1)) + 1);
      if (!w_rr_found && w_valid_pad[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_idx;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (r_starve_cnt >= 8'(STARVE_MAX) && w_lp_any) begin
          w_gvalid = 1'b1;
          w_gidx   = w_rr_idx;
        end else if (req_valid[0]) begin
          w_gvalid = 1'b1;
          w_gidx   = '0;
        end else if (w_rr_found) begin
          w_gvalid = 1'b1;
          w_gidx   = w_rr_idx;
        end
        if (clear_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_clear_cnt == 5'd31) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant    = w_gvalid ? (NUM_REQ'(1) << w_gidx) : '0;
  assign w_sel_reg  = req_reg[5*int'(w_gidx) +: 5];
  assign w_sel_data = req_data[32*int'(w_gidx) +: 32];

  // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_rr_ptr     <= 3'd1;
      r_starve_cnt <= '0;
      r_clear_cnt  <= '0;
      r_drop_count <= '0;
      r_we         <= 1'b0;
      r_wreg       <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_state == S_CLEAR) begin
        r_we        <= 1'b1;
        r_wreg      <= r_clear_cnt;
        r_wdata     <= '0;
        r_clear_cnt <= (r_clear_cnt == 5'd31) ? 5'd0 : r_clear_cnt + 5'd1;
      end else begin
        if (w_gvalid) begin
          if (w_sel_reg != 5'd0) begin
            r_we    <= 1'b1;
            r_wreg  <= w_sel_reg;
            r_wdata <= w_sel_data;
          end else if (r_drop_count != 8'hFF) begin
            r_drop_count <= r_drop_count + 8'd1;
          end
          if (w_gidx != 3'd0)
            r_rr_ptr <= (w_gidx == 3'(NUM_REQ - 1)) ? 3'd1 : w_gidx + 3'd1;
        end
        // Starvation only accrues while writeback wins over a waiting low-priority requester.
        if (w_gvalid && w_gidx == 3'd0 && w_lp_any) begin
          if (r_starve_cnt != 8'hFF) r_starve_cnt <= r_starve_cnt + 8'd1;
        end else if ((w_gvalid && w_gidx != 3'd0) || !w_lp_any) begin
          r_starve_cnt <= '0;
        end
        if (clear_start) r_clear_cnt <= 5'd1;
      end
    end
  end

  assign req_ready        = ctrl_reset ? w_grant : '0;
  assign clear_busy       = (r_state == S_CLEAR);
  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_wreg;
  assign data_writeReg    = r_wdata;
  assign drop_count       = r_drop_count;

endmodule
